// File: rtl/uart_rx_sampler_pkg.sv
// Shared widths, line constants and helper functions for the UART RX oversampling front end.
package uart_rx_sampler_pkg;

    localparam int unsigned PRESCALE_W = 6;
    localparam int unsigned BIT_CNT_W  = 4;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = PRESCALE_W'(32);
    localparam logic                  IDLE_LEVEL  = 1'b1;

    // Anything other than 8/16/32 falls back to the slowest-safe ratio of 8.
    function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
        logic [PRESCALE_W-1:0] r;
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: r = p;
            default:                              r = PRESCALE_8;
        endcase
        return r;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Control/status bundle between the RX control FSM (master) and the oversampling front end (slave).
interface uart_rx_sampler_if;
    import uart_rx_sampler_pkg::*;

    logic [PRESCALE_W-1:0] PRESCALE;
    logic                  CNT_EN;
    logic                  DAT_SAMP_EN;
    logic [PRESCALE_W-1:0] EDGE_CNT;
    logic [BIT_CNT_W-1:0]  BIT_CNT;
    logic                  BIT_DONE;
    logic                  SAMPLED_BIT;
    logic                  SAMPLE_VALID;

    modport master (
        output PRESCALE, CNT_EN, DAT_SAMP_EN,
        input  EDGE_CNT, BIT_CNT, BIT_DONE, SAMPLED_BIT, SAMPLE_VALID
    );

    modport slave (
        input  PRESCALE, CNT_EN, DAT_SAMP_EN,
        output EDGE_CNT, BIT_CNT, BIT_DONE, SAMPLED_BIT, SAMPLE_VALID
    );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Prescale latch plus per-bit edge counter and saturating frame bit counter.
module uart_rx_edge_bit_counter
    import uart_rx_sampler_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  cnt_en,
    output logic [PRESCALE_W-1:0] ps,
    output logic                  cnt_active,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  bit_done
);

    logic cnt_en_q;
    logic last_edge;

    // The enabling cycle only latches the ratio; counting proper starts one cycle later.
    assign cnt_active = cnt_en & cnt_en_q;
    assign last_edge  = (edge_cnt == PRESCALE_W'(ps - PRESCALE_W'(1)));
    assign bit_done   = cnt_active & last_edge;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_en_q <= 1'b0;
            ps       <= PRESCALE_8;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            cnt_en_q <= cnt_en;
            if (!cnt_en) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else if (!cnt_en_q) begin
                ps       <= legal_prescale(prescale);
                edge_cnt <= '0;
            end else if (last_edge) begin
                edge_cnt <= '0;
                if (bit_cnt != {BIT_CNT_W{1'b1}}) begin
                    bit_cnt <= BIT_CNT_W'(bit_cnt + BIT_CNT_W'(1));
                end
            end else begin
                edge_cnt <= PRESCALE_W'(edge_cnt + PRESCALE_W'(1));
            end
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX oversampling front end: line synchroniser, edge/bit counting and
// 3-sample majority vote around mid-bit.
module uart_rx_sampler
    import uart_rx_sampler_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    output logic               RX_SYNC,
    uart_rx_sampler_if.slave   bus
);

    logic                  sync_q;
    logic                  s0, s1, s2;
    logic [PRESCALE_W-1:0] ps;
    logic [PRESCALE_W-1:0] half;
    logic                  cnt_active;
    logic                  samp_en;
    logic                  cap0_hit, cap1_hit, cap2_hit, vote_hit;

    uart_rx_edge_bit_counter u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .prescale   (bus.PRESCALE),
        .cnt_en     (bus.CNT_EN),
        .ps         (ps),
        .cnt_active (cnt_active),
        .edge_cnt   (bus.EDGE_CNT),
        .bit_cnt    (bus.BIT_CNT),
        .bit_done   (bus.BIT_DONE)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q  <= IDLE_LEVEL;
            RX_SYNC <= IDLE_LEVEL;
        end else begin
            sync_q  <= RX_IN;
            RX_SYNC <= sync_q;
        end
    end

    // Capture points straddle mid-bit: M-1, M, M+1, vote at M+2.
    assign half     = {1'b0, ps[PRESCALE_W-1:1]};
    assign samp_en  = cnt_active & bus.DAT_SAMP_EN;
    assign cap0_hit = (bus.EDGE_CNT == PRESCALE_W'(half - PRESCALE_W'(1)));
    assign cap1_hit = (bus.EDGE_CNT == half);
    assign cap2_hit = (bus.EDGE_CNT == PRESCALE_W'(half + PRESCALE_W'(1)));
    assign vote_hit = (bus.EDGE_CNT == PRESCALE_W'(half + PRESCALE_W'(2)));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s0               <= IDLE_LEVEL;
            s1               <= IDLE_LEVEL;
            s2               <= IDLE_LEVEL;
            bus.SAMPLED_BIT  <= IDLE_LEVEL;
            bus.SAMPLE_VALID <= 1'b0;
        end else begin
            bus.SAMPLE_VALID <= 1'b0;
            if (samp_en) begin
                if (cap0_hit) s0 <= RX_SYNC;
                if (cap1_hit) s1 <= RX_SYNC;
                if (cap2_hit) s2 <= RX_SYNC;
                if (vote_hit) begin
                    bus.SAMPLED_BIT  <= majority3(s0, s1, s2);
                    bus.SAMPLE_VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler against a cycle-arithmetic reference model.
module tb_uart_rx_sampler;
    import uart_rx_sampler_pkg::*;

    logic CLK;
    logic RST;
    logic RX_IN;
    logic RX_SYNC;

    uart_rx_sampler_if bus ();

    uart_rx_sampler dut (
        .CLK     (CLK),
        .RST     (RST),
        .RX_IN   (RX_IN),
        .RX_SYNC (RX_SYNC),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   total = 0;
    int   bad   = 0;
    logic exp_sampled;
    logic rx_at [0:511];

    // Frame model: k = posedges since the enabling edge. EDGE_CNT = k mod PS,
    // BIT_CNT = min(k div PS, 15), vote visible at edge M+3 using RX_IN driven
    // at posedges k-5..k-3 (2-flop sync plus capture latency).
    task automatic run_frame(input int ps_req, input int ps_eff, input int nbits,
                             input int chg_at, input int chg_val, input int off_bits);
        int n, half, e, b, s;
        logic exp_v;
        n    = nbits * ps_eff;
        half = ps_eff / 2;
        bus.PRESCALE = PRESCALE_W'(ps_req);
        bus.CNT_EN   = 1'b1;
        for (int k = 0; k < n; k++) begin
            RX_IN = rx_at[k];
            bus.DAT_SAMP_EN = ((k / ps_eff) >= off_bits);
            if (k == chg_at) bus.PRESCALE = PRESCALE_W'(chg_val);
            @(posedge CLK); #1;
            e = k % ps_eff;
            b = k / ps_eff;
            if (b > 15) b = 15;
            exp_v = 1'b0;
            if (e == half + 3 && (k / ps_eff) >= off_bits) begin
                s = int'(rx_at[k-5]) + int'(rx_at[k-4]) + int'(rx_at[k-3]);
                exp_v = 1'b1;
                exp_sampled = (s >= 2);
            end
            total++;
            if (bus.EDGE_CNT !== PRESCALE_W'(e)) begin
                bad++; $display("FAIL edge_cnt k=%0d got=%0d exp=%0d", k, bus.EDGE_CNT, e);
            end
            total++;
            if (bus.BIT_CNT !== BIT_CNT_W'(b)) begin
                bad++; $display("FAIL bit_cnt k=%0d got=%0d exp=%0d", k, bus.BIT_CNT, b);
            end
            total++;
            if (bus.BIT_DONE !== (e == ps_eff - 1)) begin
                bad++; $display("FAIL bit_done k=%0d got=%0b exp=%0b", k, bus.BIT_DONE, (e == ps_eff - 1));
            end
            total++;
            if (bus.SAMPLE_VALID !== exp_v) begin
                bad++; $display("FAIL sample_valid k=%0d got=%0b exp=%0b", k, bus.SAMPLE_VALID, exp_v);
            end
            total++;
            if (bus.SAMPLED_BIT !== exp_sampled) begin
                bad++; $display("FAIL sampled_bit k=%0d got=%0b exp=%0b", k, bus.SAMPLED_BIT, exp_sampled);
            end
            if (k >= 1) begin
                total++;
                if (RX_SYNC !== rx_at[k-1]) begin
                    bad++; $display("FAIL rx_sync k=%0d got=%0b exp=%0b", k, RX_SYNC, rx_at[k-1]);
                end
            end
        end
        bus.CNT_EN      = 1'b0;
        bus.DAT_SAMP_EN = 1'b1;
        @(posedge CLK); #1;
        total++;
        if (bus.EDGE_CNT !== '0 || bus.BIT_CNT !== '0 || bus.BIT_DONE !== 1'b0 || bus.SAMPLE_VALID !== 1'b0) begin
            bad++; $display("FAIL frame_clear got edge=%0d bit=%0d done=%0b valid=%0b exp=0/0/0/0",
                            bus.EDGE_CNT, bus.BIT_CNT, bus.BIT_DONE, bus.SAMPLE_VALID);
        end
        total++;
        if (bus.SAMPLED_BIT !== exp_sampled) begin
            bad++; $display("FAIL frame_hold got=%0b exp=%0b", bus.SAMPLED_BIT, exp_sampled);
        end
    endtask

    task automatic fill_bits(input int ps, input int nbits, input bit glitchy);
        logic v;
        for (int k = 0; k < nbits * ps; k++) begin
            if (k % ps == 0) v = 1'($urandom_range(0, 1));
            rx_at[k] = v;
            if (glitchy && $urandom_range(0, 7) == 0) rx_at[k] = ~v;
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; RX_IN = 1'b1;
        bus.PRESCALE = PRESCALE_8; bus.CNT_EN = 1'b0; bus.DAT_SAMP_EN = 1'b1;
        exp_sampled = 1'b1;
        #12;
        total++;
        if (RX_SYNC !== 1'b1 || bus.EDGE_CNT !== '0 || bus.BIT_CNT !== '0 || bus.BIT_DONE !== 1'b0
            || bus.SAMPLED_BIT !== 1'b1 || bus.SAMPLE_VALID !== 1'b0) begin
            bad++; $display("FAIL reset_state got sync=%0b edge=%0d bit=%0d done=%0b samp=%0b valid=%0b exp=1/0/0/0/1/0",
                            RX_SYNC, bus.EDGE_CNT, bus.BIT_CNT, bus.BIT_DONE, bus.SAMPLED_BIT, bus.SAMPLE_VALID);
        end
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1; RX_IN = 1'b0;
        @(posedge CLK); #1;
        total++;
        if (RX_SYNC !== 1'b1) begin
            bad++; $display("FAIL sync_lag1 got=%0b exp=1", RX_SYNC);
        end
        @(posedge CLK); #1;
        total++;
        if (RX_SYNC !== 1'b0) begin
            bad++; $display("FAIL sync_lag2 got=%0b exp=0", RX_SYNC);
        end
        RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_basic();
        for (int k = 0; k < 16; k++) rx_at[k] = (k >= 8);
        run_frame(8, 8, 2, -1, 0, 0);
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 16; k++) rx_at[k] = 1'b0;
        rx_at[7] = 1'b1;
        run_frame(16, 16, 1, -1, 0, 0);
        total++;
        if (bus.SAMPLED_BIT !== 1'b0) begin
            bad++; $display("FAIL glitch_vote got=%0b exp=0", bus.SAMPLED_BIT);
        end
    endtask

    task automatic test_prescale();
        fill_bits(16, 3, 1'b0);
        run_frame(16, 16, 3, 20, 8, 0);
        fill_bits(8, 2, 1'b0);
        run_frame(5, 8, 2, -1, 0, 0);
    endtask

    task automatic test_samp_disable();
        for (int k = 0; k < 16; k++) rx_at[k] = ~exp_sampled;
        run_frame(8, 8, 2, -1, 0, 1);
    endtask

    task automatic test_cnt_drop();
        logic held;
        held = exp_sampled;
        RX_IN = ~held; bus.PRESCALE = PRESCALE_8; bus.DAT_SAMP_EN = 1'b1; bus.CNT_EN = 1'b1;
        repeat (7) @(posedge CLK);
        #1;
        total++;
        if (bus.EDGE_CNT !== PRESCALE_W'(6)) begin
            bad++; $display("FAIL drop_pre_edge got=%0d exp=6", bus.EDGE_CNT);
        end
        bus.CNT_EN = 1'b0;
        @(posedge CLK); #1;
        total++;
        if (bus.SAMPLE_VALID !== 1'b0 || bus.SAMPLED_BIT !== held || bus.EDGE_CNT !== '0 || bus.BIT_CNT !== '0) begin
            bad++; $display("FAIL drop_on_vote got valid=%0b samp=%0b edge=%0d bit=%0d exp=0/%0b/0/0",
                            bus.SAMPLE_VALID, bus.SAMPLED_BIT, bus.EDGE_CNT, bus.BIT_CNT, held);
        end
        RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_saturate();
        fill_bits(8, 20, 1'b1);
        run_frame(8, 8, 20, -1, 0, 0);
    endtask

    task automatic test_random();
        int ps;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 2))
                0:       ps = 8;
                1:       ps = 16;
                default: ps = 32;
            endcase
            fill_bits(ps, 4, 1'b1);
            run_frame(ps, ps, int'($urandom_range(2, 4)), -1, 0, 0);
        end
    endtask

    task automatic test_reset_midframe();
        RX_IN = 1'b0; bus.PRESCALE = PRESCALE_8; bus.DAT_SAMP_EN = 1'b1; bus.CNT_EN = 1'b1;
        repeat (30) @(posedge CLK);
        #1;
        total++;
        if (bus.EDGE_CNT !== PRESCALE_W'(5) || bus.BIT_CNT !== BIT_CNT_W'(3)) begin
            bad++; $display("FAIL rst_pre got edge=%0d bit=%0d exp=5/3", bus.EDGE_CNT, bus.BIT_CNT);
        end
        #2 RST = 1'b0;
        #1;
        exp_sampled = 1'b1;
        total++;
        if (RX_SYNC !== 1'b1 || bus.EDGE_CNT !== '0 || bus.BIT_CNT !== '0 || bus.BIT_DONE !== 1'b0
            || bus.SAMPLED_BIT !== 1'b1 || bus.SAMPLE_VALID !== 1'b0) begin
            bad++; $display("FAIL rst_async got sync=%0b edge=%0d bit=%0d done=%0b samp=%0b valid=%0b exp=1/0/0/0/1/0",
                            RX_SYNC, bus.EDGE_CNT, bus.BIT_CNT, bus.BIT_DONE, bus.SAMPLED_BIT, bus.SAMPLE_VALID);
        end
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;
        total++;
        if (bus.EDGE_CNT !== '0 || bus.SAMPLE_VALID !== 1'b0 || bus.BIT_CNT !== '0) begin
            bad++; $display("FAIL rst_restart0 got edge=%0d valid=%0b bit=%0d exp=0/0/0",
                            bus.EDGE_CNT, bus.SAMPLE_VALID, bus.BIT_CNT);
        end
        @(posedge CLK); #1;
        total++;
        if (bus.EDGE_CNT !== PRESCALE_W'(1)) begin
            bad++; $display("FAIL rst_restart1 got=%0d exp=1", bus.EDGE_CNT);
        end
        bus.CNT_EN = 1'b0; RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_prescale();
        test_samp_disable();
        test_cnt_drop();
        test_saturate();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
